operand_pair_packer: RTL and testbench



---
 rtl/operand_pair_packer_pkg.sv | 22 ++
 rtl/operand_pair_packer_pair_fifo.sv | 61 ++++++
 rtl/operand_pair_packer.sv | 127 ++++++++++++
 tb/tb_operand_pair_packer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/operand_pair_packer_pkg.sv
// Shared definitions for the operand pair packer.
// - state_t        : packer FSM states (WAIT_A = collecting first byte, WAIT_B = second)
// - DEFAULT_PAD    : value used for out_b when a trailing odd byte is flushed
// - Pair entry layout in the FIFO word is {a, b, odd}; a_lsb/b_lsb/ODD_BIT
//   give the field offsets for a given operand width.
package operand_pair_packer_pkg;

  typedef enum logic {
    ST_WAIT_A = 1'b0,
    ST_WAIT_B = 1'b1
  } state_t;

  localparam logic [7:0] DEFAULT_PAD = 8'h00;

  localparam int unsigned ODD_BIT = 0;
  localparam int unsigned B_LSB   = 1;

  function automatic int unsigned a_lsb(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/operand_pair_packer_pair_fifo.sv
// First-word-fall-through FIFO holding completed operand pairs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears storage too,
//                so the head reads zero after reset)
//   push       : write push_data (caller guarantees !full)
//   push_data  : entry to store
//   pop        : discard head entry (caller guarantees !empty)
//   head_data  : current head entry, straight from registered storage
//   count      : number of stored entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
module pair_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/operand_pair_packer.sv
// Pairs consecutive bytes of a valid/ready input stream into (a, b) operands
// and presents them through a small FWFT FIFO with its own valid/ready.
// in_last on a first byte flushes it alone, padded with PAD and flagged odd.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input byte handshake
//   in_data, in_last      : input byte and end-of-burst marker
//   out_valid/out_ready   : output pair handshake
//   out_a, out_b, out_odd : head pair (out_b = PAD when out_odd = 1)
//   pair_count            : pairs popped, wraps at 8 bits
module operand_pair_packer
  import operand_pair_packer_pkg::*;
#(
  parameter int unsigned       WIDTH = 8,
  parameter int unsigned       DEPTH = 2,
  parameter logic [WIDTH-1:0]  PAD   = WIDTH'(DEFAULT_PAD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_odd,
  output logic [7:0]       pair_count
);

  localparam int unsigned EW    = 2 * WIDTH + 1;
  localparam int unsigned A_LSB = a_lsb(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_hold;
  logic             in_xfer;
  logic             out_xfer;
  logic             push;
  logic             load_a;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head_data;
  logic             full;
  logic             empty;
  logic [$clog2(DEPTH):0] unused_count;

  // in_ready depends only on registered FIFO state, so a first byte is also
  // stalled while the FIFO is full.
  assign in_ready  = !rst & !full;
  assign out_valid = !empty;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (in_xfer) begin
      case (state)
        ST_WAIT_A: state_next = in_last ? ST_WAIT_A : ST_WAIT_B;
        ST_WAIT_B: state_next = ST_WAIT_A;
        default:   state_next = ST_WAIT_A;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    load_a    = 1'b0;
    push_data = '0;
    case (state)
      ST_WAIT_A: begin
        load_a    = in_xfer & !in_last;
        push      = in_xfer & in_last;
        push_data = {in_data, PAD, 1'b1};
      end
      ST_WAIT_B: begin
        push      = in_xfer;
        push_data = {a_hold, in_data, 1'b0};
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold     <= '0;
      pair_count <= '0;
    end else begin
      if (load_a) begin
        a_hold <= in_data;
      end
      if (out_xfer) begin
        pair_count <= pair_count + 8'd1;
      end
    end
  end

  pair_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_xfer),
    .head_data (head_data),
    .count     (unused_count),
    .full      (full),
    .empty     (empty)
  );

  assign out_a   = head_data[A_LSB +: WIDTH];
  assign out_b   = head_data[B_LSB +: WIDTH];
  assign out_odd = head_data[ODD_BIT];

endmodule

// File: tb/tb_operand_pair_packer.sv
module tb_operand_pair_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       out_odd;
  logic [7:0] pair_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  operand_pair_packer #(
    .WIDTH (8),
    .DEPTH (2),
    .PAD   (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_odd    (out_odd),
    .pair_count (pair_count)
  );

  // One record per clock: inputs held across the edge, expected outputs
  // observed just after it. a/b/odd are checked when a pair is expected
  // at the head, or when chk_ab forces it (reset zeros).
  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic       l;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic       e_odd;
    logic [7:0] e_pc;
    logic       chk_ab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d,
                              input logic l, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [7:0] e_a,
                              input logic [7:0] e_b, input logic e_odd,
                              input logic [7:0] e_pc, input logic chk_ab);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.l = l; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b; v.e_odd = e_odd;
    v.e_pc = e_pc; v.chk_ab = chk_ab;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    //              r  iv  d      l  ordy ir ov a      b      odd pc    chk_ab
    // reset: inputs ignored, everything zero
    vecs.push_back(mk(1, 1, 8'h99, 0, 0,   0, 0, 8'h00, 8'h00, 0, 8'd0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 8'h00, 0, 8'd0, 1));
    // 11,22,33,44 with out_ready=1
    vecs.push_back(mk(0, 1, 8'h11, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 1,   1, 1, 8'h11, 8'h22, 0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd1, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 1,   1, 1, 8'h33, 8'h44, 0, 8'd1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd2, 0));
    // odd flush A5, then 01,02 pair normally
    vecs.push_back(mk(0, 1, 8'hA5, 1, 0,   1, 1, 8'hA5, 8'h00, 1, 8'd2, 0));
    vecs.push_back(mk(0, 1, 8'h01, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd3, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0,   1, 1, 8'h01, 8'h02, 0, 8'd3, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd4, 0));
    // backpressure: 1..4 fill the FIFO, 5 stalls
    vecs.push_back(mk(0, 1, 8'h01, 0, 0,   1, 0, 8'h00, 8'h00, 0, 8'd4, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0,   1, 1, 8'h01, 8'h02, 0, 8'd4, 0));
    vecs.push_back(mk(0, 1, 8'h03, 0, 0,   1, 1, 8'h01, 8'h02, 0, 8'd4, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0, 0,   0, 1, 8'h01, 8'h02, 0, 8'd4, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 0,   0, 1, 8'h01, 8'h02, 0, 8'd4, 0));
    // pop frees a slot; in_ready returns the next cycle
    vecs.push_back(mk(0, 1, 8'h05, 0, 1,   1, 1, 8'h03, 8'h04, 0, 8'd5, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 0,   1, 1, 8'h03, 8'h04, 0, 8'd5, 0));
    // push and pop together with one entry stored
    vecs.push_back(mk(0, 1, 8'h06, 0, 1,   1, 1, 8'h05, 8'h06, 0, 8'd6, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd7, 0));
    // reset mid-pair discards 7E
    vecs.push_back(mk(0, 1, 8'h7E, 0, 0,   1, 0, 8'h00, 8'h00, 0, 8'd7, 0));
    vecs.push_back(mk(1, 1, 8'h55, 0, 1,   0, 0, 8'h00, 8'h00, 0, 8'd0, 1));
    vecs.push_back(mk(0, 1, 8'h01, 0, 0,   1, 0, 8'h00, 8'h00, 0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0,   1, 1, 8'h01, 8'h02, 0, 8'd0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 8'h00, 0, 8'd1, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].r; in_valid = vecs[i].iv; in_data = vecs[i].d;
      in_last = vecs[i].l; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.pair_count", i), 32'(pair_count), 32'(vecs[i].e_pc));
      if (vecs[i].e_ov || vecs[i].chk_ab) begin
        check($sformatf("v%0d.pair", i), {15'd0, out_a, out_b, out_odd},
              {15'd0, vecs[i].e_a, vecs[i].e_b, vecs[i].e_odd});
      end
    end

    // in_ready high on the first cycle after reset deasserts
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // 257 odd flushes, each popped the following cycle: count wraps to 1
    in_valid = 1'b1; in_last = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      in_data = 8'(k);
      @(posedge clk);
      #1;
      if (k == 256) check("wrap_pc255", 32'(pair_count), 32'd255);
      if (k == 257) check("wrap_pc0", 32'(pair_count), 32'd0);
      if (k == 257) check("wrap_head", {23'd0, out_a, out_odd}, {23'd0, 8'h01, 1'b1});
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_pc1", 32'(pair_count), 32'd1);
    check("wrap_drained", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
